// File: rtl/adder16_arbiter.sv
// adder16_arbiter
//   Round-robin arbiter/sequencer sharing one external add/sub unit among NREQ
//   requesters. One operation is accepted at a time. It is issued to the unit,
//   and the registered result is returned on the owner's response channel.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | arbitrate; grant the round-robin winner and latch its operands
//   ISSUE | op regs drive the unit; capture add_out/add_cout into rsp regs
//   RESP  | present result to owner; leave when the owner asserts rsp_ready
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester operation handshake (ready is one-hot)
//   req_in1/req_in2       packed operands, slice i = [i*WIDTH +: WIDTH]
//   req_as                per-requester select: 0 = add, 1 = subtract
//   rsp_valid/rsp_ready   per-requester response handshake (valid is one-hot)
//   rsp_out/rsp_cout      registered result and carry (1 = no borrow on subtract)
//   add_in1/add_in2/add_as  operands and select to the shared unit
//   add_out/add_cout      result and carry from the shared unit
module adder16_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_in1,
    input  logic [NREQ*WIDTH-1:0] req_in2,
    input  logic [NREQ-1:0]       req_as,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_out,
    output logic                  rsp_cout,
    output logic [WIDTH-1:0]      add_in1,
    output logic [WIDTH-1:0]      add_in2,
    output logic                  add_as,
    input  logic [WIDTH-1:0]      add_out,
    input  logic                  add_cout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   winner;
    logic            found;
    logic [PW:0]     scan_sum;
    logic [PW-1:0]   next_ptr;
    logic [WIDTH-1:0] op_in1;
    logic [WIDTH-1:0] op_in2;
    logic            op_as;
    logic [WIDTH-1:0] in1_arr [NREQ];
    logic [WIDTH-1:0] in2_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            in1_arr[i] = req_in1[i*WIDTH +: WIDTH];
            in2_arr[i] = req_in2[i*WIDTH +: WIDTH];
        end
    end

    // Scan offsets from the highest down so the smallest offset from rr_ptr
    // (the first valid requester in round-robin order) is the last to write.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NREQ)) begin
                scan_sum = scan_sum - (PW+1)'(NREQ);
            end
            if (req_valid[scan_sum[PW-1:0]]) begin
                found  = 1'b1;
                winner = scan_sum[PW-1:0];
            end
        end
    end

    assign req_ready = (state == IDLE && found) ? (NREQ'(1) << winner) : '0;
    assign next_ptr  = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

    assign add_in1 = op_in1;
    assign add_in2 = op_in2;
    assign add_as  = op_as;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            op_in1    <= '0;
            op_in2    <= '0;
            op_as     <= 1'b0;
            rsp_out   <= '0;
            rsp_cout  <= 1'b0;
            rsp_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_in1 <= in1_arr[winner];
                        op_in2 <= in2_arr[winner];
                        op_as  <= req_as[winner];
                        owner  <= winner;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_out   <= add_out;
                    rsp_cout  <= add_cout;
                    rsp_valid <= NREQ'(1) << owner;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder16_arbiter.sv
// tb_adder16_arbiter
//   Bench for adder16_arbiter with a behavioural model of the shared add/sub
//   unit. Expected results come from plain arithmetic on the accepted operands;
//   expected grants come from a round-robin pointer kept by the bench.
module tb_adder16_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_in1 = '0;
    logic [NREQ*W-1:0] req_in2 = '0;
    logic [NREQ-1:0]   req_as = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready = '1;
    logic [W-1:0]      rsp_out;
    logic              rsp_cout;
    logic [W-1:0]      add_in1;
    logic [W-1:0]      add_in2;
    logic              add_as;
    logic [W-1:0]      add_out;
    logic              add_cout;

    adder16_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_as(req_as),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_cout(rsp_cout),
        .add_in1(add_in1), .add_in2(add_in2), .add_as(add_as),
        .add_out(add_out), .add_cout(add_cout)
    );

    // Shared unit: in1 + (in2 ^ {16{as}}) + as
    assign {add_cout, add_out} = {1'b0, add_in1} + {1'b0, add_in2 ^ {W{add_as}}} + {{W{1'b0}}, add_as};

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [W-1:0] out;
        logic        cout;
        int          acyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   model_ptr = 0;
    int   last_acc_cyc = -100;
    bit   chk_spacing = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_winner(input logic [NREQ-1:0] v, input int ptr);
        int w;
        w = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (v[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
        end
        return w;
    endfunction

    // Stimulus side: every accepted operation pushes its expected response.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_acc_cyc = -100;
        end else begin
            if (rsp_valid != '0) check("ready_low_while_resp", 32'(req_ready), 0);
            if ((req_ready & req_valid) != '0) begin
                int w;
                exp_t e;
                logic [W-1:0] a, b;
                logic [W:0] s;
                w = exp_winner(req_valid, model_ptr);
                check("grant", 32'(req_ready), 32'(1 << w));
                if (chk_spacing && last_acc_cyc >= 0) check("accept_spacing", cyc - last_acc_cyc, 3);
                last_acc_cyc = cyc;
                a = req_in1[w*W +: W];
                b = req_in2[w*W +: W];
                if (!req_as[w]) begin
                    s = {1'b0, a} + {1'b0, b};
                    e.out  = s[W-1:0];
                    e.cout = s[W];
                end else begin
                    e.out  = a - b;
                    e.cout = (a >= b);
                end
                e.idx  = w;
                e.acyc = cyc;
                q.push_back(e);
            end
        end
    end

    // Monitor side: pops and compares whenever a response is presented.
    logic [NREQ-1:0] prev_rv = '0;
    logic [W-1:0]    held_out = '0;
    logic            held_cout = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            model_ptr = 0;
            prev_rv   = '0;
        end else begin
            if (rsp_valid != '0) begin
                if (prev_rv == '0) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL rsp_unexpected: got rsp_valid 0x%0h, expected none", rsp_valid);
                    end else begin
                        check("rsp_valid_owner", 32'(rsp_valid), 32'(1 << q[0].idx));
                        check("latency", cyc - q[0].acyc, 2);
                        check("rsp_out", 32'(rsp_out), 32'(q[0].out));
                        check("rsp_cout", 32'(rsp_cout), 32'(q[0].cout));
                    end
                    held_out  = rsp_out;
                    held_cout = rsp_cout;
                end else begin
                    check("rsp_valid_stable", 32'(rsp_valid), 32'(prev_rv));
                    check("rsp_out_stable", 32'(rsp_out), 32'(held_out));
                    check("rsp_cout_stable", 32'(rsp_cout), 32'(held_cout));
                end
                if ((rsp_valid & rsp_ready) != '0 && q.size() > 0) begin
                    model_ptr = (q[0].idx + 1) % NREQ;
                    void'(q.pop_front());
                end
            end
            prev_rv = rsp_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom % 5)
            0: return '0;
            1: return 16'hFFFF;
            2: return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic new_data(input int i);
        req_in1[i*W +: W] = rand_val();
        req_in2[i*W +: W] = rand_val();
        req_as[i]         = 1'($urandom % 2);
    endtask

    task automatic serve_one(output int idx, input bit keep);
        bit got;
        got = 1'b0;
        idx = -1;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    idx = i;
                    got = 1'b1;
                end
            end
            tick();
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no grant in 40 cycles, expected one");
        end else begin
            if (!keep) req_valid[idx] = 1'b0;
            new_data(idx);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            tick();
            if (q.size() == 0 && rsp_valid == '0) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", q.size());
        end
    endtask

    task automatic do_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int idx;
        req_in1[i*W +: W] = a;
        req_in2[i*W +: W] = b;
        req_as[i]         = s;
        req_valid[i]      = 1'b1;
        serve_one(idx, 1'b0);
        check("directed_grant", idx, i);
        drain();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_out"}, 32'(rsp_out), 0);
        check({tag, "_rsp_cout"}, 32'(rsp_cout), 0);
        check({tag, "_add_in1"}, 32'(add_in1), 0);
        check({tag, "_add_in2"}, 32'(add_in2), 0);
        check({tag, "_add_as"}, 32'(add_as), 0);
    endtask

    initial begin
        int idx;
        int order[6];
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};

        #1;
        check_zero_outputs("reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        do_op(0, 16'h1234, 16'h0001, 1'b0);
        do_op(2, 16'h0005, 16'h0007, 1'b1);
        do_op(2, 16'h0007, 16'h0005, 1'b1);
        do_op(1, 16'hFFFF, 16'h0001, 1'b0);
        do_op(1, 16'h8000, 16'h8000, 1'b0);

        // All requesters valid from reset: round-robin order, 3-cycle spacing
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) new_data(i);
        req_valid = '1;
        repeat (2) tick();
        chk_spacing = 1'b1;
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            serve_one(idx, 1'b1);
            order[n] = idx;
        end
        req_valid   = '0;
        chk_spacing = 1'b0;
        for (int n = 0; n < 6; n++) check("rr_order", order[n], exp_order[n]);
        drain();

        // Response back-pressure: result held, other requester not granted
        new_data(0);
        new_data(1);
        req_valid[1:0] = 2'b11;
        rsp_ready = '0;
        serve_one(idx, 1'b0);
        for (int t = 0; t < 5 && rsp_valid == '0; t++) tick();
        repeat (5) tick();
        check("pending_still_valid", 32'(req_valid[1:0] != 2'b00), 1);
        rsp_ready = '1;
        serve_one(idx, 1'b0);
        drain();

        // Reset during ISSUE drops the operation and restarts arbitration at 0
        new_data(2);
        req_valid[2] = 1'b1;
        serve_one(idx, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        new_data(1);
        new_data(3);
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        serve_one(idx, 1'b0);
        check("post_reset_grant", idx, 1);
        serve_one(idx, 1'b0);
        check("post_reset_second", idx, 3);
        drain();

        // Randomized traffic with random response back-pressure
        for (int c = 0; c < 600; c++) begin
            logic [NREQ-1:0] acc;
            @(negedge clk);
            acc = req_ready & req_valid;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    new_data(i);
                    req_valid[i] = 1'($urandom % 2);
                end else if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    new_data(i);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = NREQ'($urandom) | NREQ'($urandom);
        end
        req_valid = '0;
        rsp_ready = '1;
        drain();
        check("scoreboard_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
